// File: rtl/wdt_windowed.sv
// Windowed watchdog timer: early-warning interrupt, early-kick detection,
// sticky configuration lock, stretched system-reset pulse and reset-cause capture.
module wdt_windowed #(
  parameter int CNT_W     = 24,
  parameter int RST_PULSE = 4,
  parameter int WARN_DEF  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             kick,
  input  logic             ld_en,
  input  logic [CNT_W-1:0] ld_cnt,
  input  logic [CNT_W-1:0] ld_win,
  input  logic [CNT_W-1:0] ld_warn,
  input  logic             lock,
  output logic             rst_int,
  output logic             rst_sys,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       state,
  output logic [1:0]       cause
);

  localparam int PC_W = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam logic [PC_W-1:0] PC_LAST     = PC_W'(RST_PULSE - 1);
  localparam logic [1:0]      CAUSE_NONE  = 2'b00;
  localparam logic [1:0]      CAUSE_TMO   = 2'b01;
  localparam logic [1:0]      CAUSE_EARLY = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_WARN = 2'b10,
    ST_BITE = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_reload;
  logic [CNT_W-1:0] r_win;
  logic [CNT_W-1:0] r_warn;
  logic             r_locked;
  logic             r_int;
  logic             r_sys;
  logic [1:0]       r_cause;
  logic [PC_W-1:0]  r_pulse;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_int_nxt;
  logic             w_sys_nxt;
  logic [1:0]       w_cause_nxt;
  logic [PC_W-1:0]  w_pulse_nxt;

  logic             w_en_eff;
  logic             w_load;
  logic [CNT_W-1:0] w_ld_clamp;
  logic             w_kick_ok;
  logic             w_warn_hit;
  logic [CNT_W-1:0] w_cnt_dec;

  assign w_en_eff   = en | r_locked;
  assign w_load     = ld_en & ~r_locked;
  assign w_ld_clamp = (ld_cnt == {CNT_W{1'b0}}) ? CNT_W'(1) : ld_cnt;
  assign w_kick_ok  = (r_cnt <= r_win);
  // Warning only fires when the threshold is non-zero and actually below the reload value
  assign w_warn_hit = (r_warn != {CNT_W{1'b0}}) && (r_warn < r_reload) && (r_cnt == r_warn);
  assign w_cnt_dec  = r_cnt - CNT_W'(1);

  // Next-state, counter and pulse sequencing for the watchdog FSM
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_int_nxt   = 1'b0;
    w_sys_nxt   = r_sys;
    w_cause_nxt = r_cause;
    w_pulse_nxt = r_pulse;
    case (r_state)
      ST_IDLE: begin
        w_sys_nxt = 1'b0;
        if (w_en_eff) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_load ? w_ld_clamp : r_reload;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN, ST_WARN: begin
        w_sys_nxt = 1'b0;
        if (!w_en_eff) begin
          w_state_nxt = ST_IDLE;
        end else if (w_load) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = w_ld_clamp;
        end else if (kick) begin
          if (w_kick_ok) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = r_reload;
          end else begin
            w_state_nxt = ST_BITE;
            w_sys_nxt   = 1'b1;
            w_pulse_nxt = {PC_W{1'b0}};
            w_cause_nxt = CAUSE_EARLY;
          end
        end else if ((r_state == ST_RUN) && w_warn_hit) begin
          w_state_nxt = ST_WARN;
          w_int_nxt   = 1'b1;
          w_cnt_nxt   = w_cnt_dec;
        end else if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = ST_BITE;
          w_sys_nxt   = 1'b1;
          w_pulse_nxt = {PC_W{1'b0}};
          w_cause_nxt = CAUSE_TMO;
        end else begin
          w_cnt_nxt = w_cnt_dec;
        end
      end
      ST_BITE: begin
        // rst_sys is raised on entry, so BITE lasts exactly RST_PULSE cycles
        if (r_pulse == PC_LAST) begin
          w_state_nxt = w_en_eff ? ST_RUN : ST_IDLE;
          w_cnt_nxt   = r_reload;
          w_sys_nxt   = 1'b0;
          w_pulse_nxt = {PC_W{1'b0}};
        end else begin
          w_sys_nxt   = 1'b1;
          w_pulse_nxt = r_pulse + PC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_sys_nxt   = 1'b0;
        w_pulse_nxt = {PC_W{1'b0}};
      end
    endcase
  end

  // FSM state, counter and registered output flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_int   <= 1'b0;
      r_sys   <= 1'b0;
      r_cause <= CAUSE_NONE;
      r_pulse <= {PC_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_int   <= w_int_nxt;
      r_sys   <= w_sys_nxt;
      r_cause <= w_cause_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  // Configuration hold registers and the sticky lock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reload <= {CNT_W{1'b1}};
      r_win    <= {CNT_W{1'b1}};
      r_warn   <= CNT_W'(WARN_DEF);
      r_locked <= 1'b0;
    end else begin
      if (lock) begin
        r_locked <= 1'b1;
      end
      if (w_load) begin
        r_reload <= w_ld_clamp;
        r_win    <= ld_win;
        r_warn   <= ld_warn;
      end
    end
  end

  assign rst_int = r_int;
  assign rst_sys = r_sys;
  assign cnt     = r_cnt;
  assign state   = r_state;
  assign cause   = r_cause;

endmodule

// File: tb/tb_wdt_windowed.sv
// Self-checking bench for wdt_windowed: directed scenario tasks plus a
// randomized run compared cycle by cycle against a rule-level model.
module tb_wdt_windowed;
  localparam int CNT_W     = 24;
  localparam int RST_PULSE = 4;
  localparam int WARN_DEF  = 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_WARN = 2'd2;
  localparam logic [1:0] S_BITE = 2'd3;
  localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst_n, en, kick, ld_en, lock;
  logic [CNT_W-1:0] ld_cnt, ld_win, ld_warn;
  logic             rst_int, rst_sys;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state, cause;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [1:0]       m_mode;
  logic [CNT_W-1:0] m_cnt, m_reload, m_win, m_warn;
  logic             m_locked, m_int, m_sys;
  logic [1:0]       m_cause;
  int               m_left;

  always #5 clk = ~clk;

  wdt_windowed #(.CNT_W(CNT_W), .RST_PULSE(RST_PULSE), .WARN_DEF(WARN_DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .kick(kick), .ld_en(ld_en),
    .ld_cnt(ld_cnt), .ld_win(ld_win), .ld_warn(ld_warn), .lock(lock),
    .rst_int(rst_int), .rst_sys(rst_sys), .cnt(cnt), .state(state), .cause(cause)
  );

  task automatic model_step();
    logic             active, loading;
    logic [CNT_W-1:0] clamp;
    if (!rst_n) begin
      m_mode = S_IDLE; m_cnt = '0; m_reload = ONES; m_win = ONES;
      m_warn = CNT_W'(WARN_DEF); m_locked = 1'b0; m_int = 1'b0;
      m_sys = 1'b0; m_cause = 2'b00; m_left = 0;
      return;
    end
    active  = en || m_locked;
    loading = ld_en && !m_locked;
    clamp   = (ld_cnt == '0) ? CNT_W'(1) : ld_cnt;
    m_int   = 1'b0;
    if (m_mode == S_IDLE) begin
      if (active) begin
        m_mode = S_RUN;
        m_cnt  = loading ? clamp : m_reload;
      end
    end else if (m_mode == S_BITE) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_mode = active ? S_RUN : S_IDLE;
        m_cnt  = m_reload;
      end
    end else begin
      if (!active) m_mode = S_IDLE;
      else if (loading) begin m_mode = S_RUN; m_cnt = clamp; end
      else if (kick && m_cnt <= m_win) begin m_mode = S_RUN; m_cnt = m_reload; end
      else if (kick) begin m_mode = S_BITE; m_left = RST_PULSE; m_cause = 2'b10; end
      else if (m_mode == S_RUN && m_warn != '0 && m_warn < m_reload && m_cnt == m_warn) begin
        m_mode = S_WARN; m_int = 1'b1; m_cnt = m_cnt - CNT_W'(1);
      end
      else if (m_cnt == '0) begin m_mode = S_BITE; m_left = RST_PULSE; m_cause = 2'b01; end
      else m_cnt = m_cnt - CNT_W'(1);
    end
    if (loading) begin m_reload = clamp; m_win = ld_win; m_warn = ld_warn; end
    if (lock) m_locked = 1'b1;
    m_sys = (m_mode == S_BITE);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [CNT_W-1:0] c, input logic [CNT_W-1:0] w,
                         input logic [CNT_W-1:0] wr);
    ld_en = 1'b1; ld_cnt = c; ld_win = w; ld_warn = wr;
    cycle();
    ld_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle(); cycle();
    n_checks++;
    if ({state, cnt, cause, rst_int, rst_sys} !== {S_IDLE, 24'd0, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got state=%0d cnt=%0d cause=%0d int=%0b sys=%0b, want 0/0/0/0/0",
               state, cnt, cause, rst_int, rst_sys);
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if (state !== S_IDLE || cnt !== 24'd0) begin
      n_fail++;
      $display("FAIL idle_hold: got state=%0d cnt=%0d, want 0/0", state, cnt);
    end
  endtask

  task automatic test_timeout();
    int k = 0, ints = 0, hi = 0;
    do_load(24'd10, 24'd10, 24'd3);
    en = 1'b1;
    cycle();
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd10) begin
      n_fail++; $display("FAIL reload: got state=%0d cnt=%0d, want 1/10", state, cnt);
    end
    for (int i = 0; i < 40; i++) begin
      cycle(); k++;
      n_checks++;
      if ({state, cnt, rst_int, rst_sys} !== {m_mode, m_cnt, m_int, m_sys}) begin
        n_fail++;
        $display("FAIL timeout_model: got state=%0d cnt=%0d int=%0b, want %0d/%0d/%0b",
                 state, cnt, rst_int, m_mode, m_cnt, m_int);
      end
      if (rst_int) begin
        ints++;
        n_checks++;
        if (state !== S_WARN || cnt !== 24'd2) begin
          n_fail++; $display("FAIL warn_entry: got state=%0d cnt=%0d, want 2/2", state, cnt);
        end
      end
      if (state == S_BITE) break;
    end
    n_checks++;
    if (k != 11 || ints != 1 || cause !== 2'b01) begin
      n_fail++;
      $display("FAIL timeout_period: got cycles=%0d ints=%0d cause=%0d, want 11/1/1", k, ints, cause);
    end
    for (int i = 0; i < 20; i++) begin
      if (!rst_sys) break;
      hi++; cycle();
    end
    n_checks++;
    if (hi != RST_PULSE || state !== S_RUN || cnt !== 24'd10) begin
      n_fail++;
      $display("FAIL timeout_pulse: got sys_cycles=%0d state=%0d cnt=%0d, want 4/1/10", hi, state, cnt);
    end
  endtask

  task automatic test_window();
    int hi = 0;
    do_load(24'd10, 24'd5, 24'd3);
    cycle(); cycle();
    n_checks++;
    if (cnt !== 24'd8) begin
      n_fail++; $display("FAIL win_pre: got cnt=%0d, want 8", cnt);
    end
    kick = 1'b1; cycle();
    n_checks++;
    if (state !== S_BITE || cause !== 2'b10 || rst_sys !== 1'b1) begin
      n_fail++;
      $display("FAIL early_kick: got state=%0d cause=%0d sys=%0b, want 3/2/1", state, cause, rst_sys);
    end
    for (int i = 0; i < 20; i++) begin
      if (!rst_sys) break;
      hi++; cycle();
    end
    kick = 1'b0;
    n_checks++;
    if (hi != RST_PULSE || state !== S_RUN || cnt !== 24'd10) begin
      n_fail++;
      $display("FAIL early_pulse: got sys_cycles=%0d state=%0d cnt=%0d, want 4/1/10", hi, state, cnt);
    end
    for (int i = 0; i < 30; i++) begin
      if (cnt == 24'd4) break;
      cycle();
    end
    kick = 1'b1; cycle(); kick = 1'b0;
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd10 || rst_sys !== 1'b0) begin
      n_fail++;
      $display("FAIL legal_kick: got state=%0d cnt=%0d sys=%0b, want 1/10/0", state, cnt, rst_sys);
    end
  endtask

  task automatic test_warn_service();
    int ints = 0, seen = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (rst_int) ints++;
      if (rst_sys) seen++;
      if (state == S_WARN && cnt == 24'd2) break;
    end
    kick = 1'b1; cycle(); kick = 1'b0;
    if (rst_int) ints++;
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd10 || ints != 1 || seen != 0) begin
      n_fail++;
      $display("FAIL warn_kick: got state=%0d cnt=%0d ints=%0d sys_seen=%0d, want 1/10/1/0",
               state, cnt, ints, seen);
    end
  endtask

  task automatic test_lock();
    int k = 0, ints = 0;
    lock = 1'b1; cycle(); lock = 1'b0;
    en = 1'b0;
    do_load(24'd50, 24'd50, 24'd0);
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd8) begin
      n_fail++; $display("FAIL lock_ignore: got state=%0d cnt=%0d, want 1/8", state, cnt);
    end
    for (int i = 0; i < 10; i++) begin
      if (cnt <= 24'd5) break;
      cycle();
    end
    kick = 1'b1; cycle(); kick = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(); k++;
      if (rst_int) ints++;
      if (state == S_BITE) break;
    end
    n_checks++;
    if (k != 11 || ints != 1 || cause !== 2'b01) begin
      n_fail++;
      $display("FAIL lock_period: got cycles=%0d ints=%0d cause=%0d, want 11/1/1", k, ints, cause);
    end
    for (int i = 0; i < 20; i++) begin
      if (!rst_sys) break;
      cycle();
    end
    n_checks++;
    if (state !== S_RUN) begin
      n_fail++; $display("FAIL lock_rerun: got state=%0d, want 1", state);
    end
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    n_checks++;
    if (state !== S_IDLE || cnt !== 24'd0) begin
      n_fail++; $display("FAIL lock_reset: got state=%0d cnt=%0d, want 0/0", state, cnt);
    end
    en = 1'b1; cycle(); en = 1'b0; cycle();
    n_checks++;
    if (state !== S_IDLE || cnt !== ONES) begin
      n_fail++; $display("FAIL unlock_stop: got state=%0d cnt=%0h, want 0/ffffff", state, cnt);
    end
  endtask

  task automatic test_corner_loads();
    int k = 0, ints = 0;
    en = 1'b1; cycle();
    kick = 1'b1;
    do_load(24'd20, ONES, 24'd3);
    kick = 1'b0;
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd20) begin
      n_fail++; $display("FAIL load_beats_kick: got state=%0d cnt=%0d, want 1/20", state, cnt);
    end
    do_load(24'd0, ONES, 24'd3);
    n_checks++;
    if (cnt !== 24'd1) begin
      n_fail++; $display("FAIL clamp_load: got cnt=%0d, want 1", cnt);
    end
    cycle(); cycle();
    n_checks++;
    if (state !== S_BITE || cause !== 2'b01 || rst_int !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_bite: got state=%0d cause=%0d int=%0b, want 3/1/0", state, cause, rst_int);
    end
    for (int i = 0; i < 20; i++) begin
      if (!rst_sys) break;
      cycle();
    end
    n_checks++;
    if (state !== S_RUN || cnt !== 24'd1) begin
      n_fail++; $display("FAIL clamp_reload: got state=%0d cnt=%0d, want 1/1", state, cnt);
    end
    do_load(24'd6, ONES, 24'd0);
    for (int i = 0; i < 20; i++) begin
      cycle(); k++;
      if (rst_int) ints++;
      if (state == S_BITE) break;
    end
    n_checks++;
    if (k != 7 || ints != 0 || cause !== 2'b01) begin
      n_fail++;
      $display("FAIL warn_off: got cycles=%0d ints=%0d cause=%0d, want 7/0/1", k, ints, cause);
    end
  endtask

  task automatic test_reset_mid_bite();
    cycle();
    n_checks++;
    if (state !== S_BITE || rst_sys !== 1'b1) begin
      n_fail++; $display("FAIL bite_2nd: got state=%0d sys=%0b, want 3/1", state, rst_sys);
    end
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    n_checks++;
    if ({state, cnt, cause, rst_sys, rst_int} !== {S_IDLE, 24'd0, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_bite_reset: got state=%0d cnt=%0d cause=%0d sys=%0b, want 0/0/0/0",
               state, cnt, cause, rst_sys);
    end
  endtask

  task automatic test_random();
    int shown = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_n   = ($urandom_range(0, 199) != 0);
      en      = ($urandom_range(0, 9) != 0);
      kick    = ($urandom_range(0, 5) == 0);
      ld_en   = ($urandom_range(0, 11) == 0);
      lock    = ($urandom_range(0, 499) == 0);
      ld_cnt  = CNT_W'($urandom_range(0, 20));
      ld_win  = CNT_W'($urandom_range(0, 20));
      ld_warn = CNT_W'($urandom_range(0, 8));
      cycle();
      n_checks++;
      if ({state, cnt, cause, rst_int, rst_sys} !== {m_mode, m_cnt, m_cause, m_int, m_sys}) begin
        n_fail++;
        if (shown < 10) begin
          shown++;
          $display("FAIL random_model cyc %0d: got state=%0d cnt=%0d cause=%0d int=%0b sys=%0b, want %0d/%0d/%0d/%0b/%0b",
                   i, state, cnt, cause, rst_int, rst_sys, m_mode, m_cnt, m_cause, m_int, m_sys);
        end
      end
    end
    rst_n = 1'b1; ld_en = 1'b0; kick = 1'b0; lock = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; kick = 1'b0; ld_en = 1'b0; lock = 1'b0;
    ld_cnt = '0; ld_win = '0; ld_warn = '0;
    test_reset();
    test_timeout();
    test_window();
    test_warn_service();
    test_lock();
    test_corner_loads();
    test_reset_mid_bite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wdt_windowed.md
Name: wdt_windowed

Overview:
- Parametrised second-generation watchdog timer with:
  - configurable counter width;
  - programmable early-warning threshold;
  - window mode, where a kick that arrives too early is a violation;
  - a sticky configuration lock;
  - a stretched system-reset pulse;
  - a reset-cause register.
- Sits between the CPU's kick/config interface and the system reset controller.
- rst_int goes to the interrupt controller; rst_sys goes to the reset generator.

Parameters:
CNT_W, 24, counter and load-value width
RST_PULSE, 4, number of cycles rst_sys is held high per bite (>=1)
WARN_DEF, 3, warning threshold loaded at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
en  input  1  watchdog enable
kick  input  1  service request, sampled every cycle
ld_en  input  1  load strobe for ld_cnt/ld_win/ld_warn
ld_cnt  input  CNT_W  timeout reload value
ld_win  input  CNT_W  window-open threshold; a kick is legal only when counter <= win
ld_warn  input  CNT_W  warning threshold
lock  input  1  sets sticky lock bit
rst_int  output  1  early-warning interrupt, 1-cycle pulse
rst_sys  output  1  system reset request, RST_PULSE cycles high
cnt  output  CNT_W  current counter value
state  output  2  00 IDLE, 01 RUN, 10 WARN, 11 BITE
cause  output  2  last bite cause: 00 none, 01 timeout, 10 early kick

Behaviour:
- Reset (rst_n=0 at clk edge):
  - counter=0; reload_hld={CNT_W{1}}; win_hld={CNT_W{1}}, so the window is always open.
  - warn_hld=WARN_DEF; locked=0; state=IDLE; rst_int=0; rst_sys=0; cause=00; pulse counter=0.
  - Reset overrides everything, including a bite in progress.
- Priority per edge: rst_n > BITE sequencing > ld_en > kick > decrement.
- Effective enable: en_eff = en | locked.
- lock=1 sets locked; locked clears only on rst_n. While locked:
  - ld_en is ignored;
  - en=0 cannot stop the timer.
- ld_en (unlocked only):
  - reload_hld=ld_cnt, with 0 clamped to 1; win_hld=ld_win; warn_hld=ld_warn.
  - In RUN/WARN: counter=clamped ld_cnt and state=RUN (a load counts as a kick, no window check).
  - In BITE: the hold registers update only; sequencing continues.
- IDLE:
  - counter holds.
  - en_eff=1 -> RUN, counter=reload_hld.
- RUN:
  - en_eff=0 -> IDLE, counter holds.
  - Kick with counter<=win_hld -> counter=reload_hld, stay RUN.
  - Kick with counter>win_hld -> BITE, cause=10.
  - No kick and counter==warn_hld, with warn_hld!=0 and warn_hld<reload_hld -> WARN, rst_int=1 for the next cycle only, counter decrements.
  - No kick and counter==0 (warning disabled) -> BITE, cause=01.
  - Otherwise counter=counter-1.
- WARN:
  - en_eff=0 -> IDLE.
  - Legal kick -> RUN, counter=reload_hld.
  - Early kick -> BITE, cause=10.
  - counter==0 -> BITE, cause=01.
  - Otherwise decrement.
- Timeout period: reload_hld+1 cycles from reload to BITE entry.
- BITE:
  - rst_sys=1 for exactly RST_PULSE cycles starting the cycle after entry.
  - Kicks are ignored.
  - On the last pulse cycle: counter=reload_hld; state=RUN if en_eff, else IDLE; rst_sys drops the following cycle.
- Arithmetic:
  - Counter never wraps below 0.
  - All comparisons are unsigned CNT_W-bit.
- Outputs:
  - rst_int and rst_sys are registered.
  - cause holds until the next bite or reset.
  - cnt and state reflect registers directly.
- Simultaneous events:
  - Kick at counter==0 in WARN: the kick wins if legal.
  - ld_en+kick in the same cycle: the load wins.
  - Early kick at counter==warn_hld: BITE (no rst_int).

Test Plan:
- Timeout: CNT_W=24, RST_PULSE=4, WARN_DEF=3; ld_cnt=10, ld_win=10, ld_warn=3, en=1, no kicks -> rst_int single pulse when counter leaves 3, state=WARN; BITE after 11 cycles from reload; rst_sys high exactly 4 cycles; cause=01; counter restarts at 10.
- Window: ld_win=5, ld_cnt=10; kick at cnt=8 -> BITE next edge, cause=10, rst_sys 4 cycles. Kick at cnt=4 -> cnt=10, state RUN, no rst_sys.
- Warning service: no kick until WARN, kick at cnt=2 -> rst_int had exactly one pulse, state=RUN, cnt=10, rst_sys never asserted.
- Lock: lock=1, then en=0 and ld_en with ld_cnt=50 -> both ignored, timer still bites at original period. Pulse rst_n=0 -> locked cleared; en=0 now returns to IDLE.
- Corner loads: ld_en+kick in the same cycle, ld_cnt=20 -> cnt=20 next cycle. ld_cnt=0 -> reload_hld=1. ld_warn=0 -> no rst_int, direct timeout bite.
- Reset mid-bite: rst_n=0 during the 2nd rst_sys cycle -> next edge rst_sys=0, state=IDLE, cause=00, cnt=0.
